// File: rtl/proc_pkg.sv
// Shared constants for the pipelined processor: datapath widths, ALU opcodes
// and the EX/MEM pipeline register layout.
package proc_pkg;

    localparam int DATA_W = 32;
    localparam int PC_W   = 8;
    localparam int RA_W   = 5;
    localparam int OP_W   = 5;

    localparam logic [OP_W-1:0] ALU_ADD   = 5'd0;
    localparam logic [OP_W-1:0] ALU_SUB   = 5'd1;
    localparam logic [OP_W-1:0] ALU_AND   = 5'd2;
    localparam logic [OP_W-1:0] ALU_OR    = 5'd3;
    localparam logic [OP_W-1:0] ALU_XOR   = 5'd4;
    localparam logic [OP_W-1:0] ALU_NOR   = 5'd5;
    localparam logic [OP_W-1:0] ALU_SLT   = 5'd6;
    localparam logic [OP_W-1:0] ALU_SLTU  = 5'd7;
    localparam logic [OP_W-1:0] ALU_SLL   = 5'd8;
    localparam logic [OP_W-1:0] ALU_SRL   = 5'd9;
    localparam logic [OP_W-1:0] ALU_SRA   = 5'd10;
    localparam logic [OP_W-1:0] ALU_LUI   = 5'd11;
    localparam logic [OP_W-1:0] ALU_PASSB = 5'd12;
    localparam logic [OP_W-1:0] ALU_BEQ   = 5'd13;
    localparam logic [OP_W-1:0] ALU_BNE   = 5'd14;

    typedef struct packed {
        logic [DATA_W-1:0] alu_result;
        logic [DATA_W-1:0] write_data;
        logic [RA_W-1:0]   write_reg;
        logic              mem_write;
        logic              mem_to_reg;
        logic              reg_write;
        logic              mem_read;
        logic              branch_taken;
        logic [PC_W-1:0]   branch_target;
    } ex_mem_t;

endpackage

// File: rtl/ex_stage_if.sv
// ID/EX inputs and EX/MEM outputs of the execute stage, bundled as one interface.
interface ex_stage_if;
    import proc_pkg::*;

    logic [DATA_W-1:0] ID_EX_ReadData1;
    logic [DATA_W-1:0] ID_EX_ReadData2;
    logic [DATA_W-1:0] ID_EX_SignExtImm;
    logic [RA_W-1:0]   ID_EX_Rb;
    logic [RA_W-1:0]   ID_EX_Rd;
    logic [PC_W-1:0]   ID_EX_PC;
    logic              ID_EX_RegDst;
    logic              ID_EX_ALUSrc;
    logic              ID_EX_MemtoReg;
    logic              ID_EX_RegWrite;
    logic              ID_EX_MemRead;
    logic              ID_EX_MemWrite;
    logic              ID_EX_Branch;
    logic [OP_W-1:0]   ID_EX_ALUOp;

    logic [DATA_W-1:0] EX_MEM_ALUResult;
    logic [DATA_W-1:0] EX_MEM_WriteData;
    logic [RA_W-1:0]   EX_MEM_WriteReg;
    logic              EX_MEM_MemWriteOut;
    logic              EX_MEM_MemtoRegOut;
    logic              EX_MEM_RegWrite;
    logic              EX_MEM_MemReadOut;
    logic              EX_MEM_Branch;
    logic [PC_W-1:0]   EX_MEM_BranchTarget;

    modport master (
        output ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm, ID_EX_Rb, ID_EX_Rd,
               ID_EX_PC, ID_EX_RegDst, ID_EX_ALUSrc, ID_EX_MemtoReg, ID_EX_RegWrite,
               ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch, ID_EX_ALUOp,
        input  EX_MEM_ALUResult, EX_MEM_WriteData, EX_MEM_WriteReg, EX_MEM_MemWriteOut,
               EX_MEM_MemtoRegOut, EX_MEM_RegWrite, EX_MEM_MemReadOut, EX_MEM_Branch,
               EX_MEM_BranchTarget
    );

    modport slave (
        input  ID_EX_ReadData1, ID_EX_ReadData2, ID_EX_SignExtImm, ID_EX_Rb, ID_EX_Rd,
               ID_EX_PC, ID_EX_RegDst, ID_EX_ALUSrc, ID_EX_MemtoReg, ID_EX_RegWrite,
               ID_EX_MemRead, ID_EX_MemWrite, ID_EX_Branch, ID_EX_ALUOp,
        output EX_MEM_ALUResult, EX_MEM_WriteData, EX_MEM_WriteReg, EX_MEM_MemWriteOut,
               EX_MEM_MemtoRegOut, EX_MEM_RegWrite, EX_MEM_MemReadOut, EX_MEM_Branch,
               EX_MEM_BranchTarget
    );

endinterface

// File: rtl/alu32.sv
// Purely combinational ALU; arithmetic wraps modulo 2^DATA_W, no overflow flag.
module alu32
    import proc_pkg::*;
(
    input  logic [DATA_W-1:0] a,
    input  logic [DATA_W-1:0] b,
    input  logic [OP_W-1:0]   op,
    output logic [DATA_W-1:0] result,
    output logic              zero
);

    logic [4:0] shamt;

    assign shamt = b[4:0];

    always_comb begin
        // NOTE: default first so every path assigns result and no latch is inferred.
        result = '0;
        case (op)
            ALU_ADD:   result = a + b;
            ALU_SUB:   result = a - b;
            ALU_AND:   result = a & b;
            ALU_OR:    result = a | b;
            ALU_XOR:   result = a ^ b;
            ALU_NOR:   result = ~(a | b);
            ALU_SLT:   result = {{(DATA_W-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU:  result = {{(DATA_W-1){1'b0}}, (a < b)};
            ALU_SLL:   result = a << shamt;
            ALU_SRL:   result = a >> shamt;
            ALU_SRA:   result = $unsigned($signed(a) >>> shamt);
            ALU_LUI:   result = b << 16;
            ALU_PASSB: result = b;
            ALU_BEQ,
            ALU_BNE:   result = a - b;
            default:   result = '0;
        endcase
    end

    assign zero = (result == '0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand select, ALU, branch resolution and destination select,
// all captured in the EX/MEM pipeline register every cycle.
module ex_stage
    import proc_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    ex_stage_if.slave  bus
);

    logic [DATA_W-1:0] op_b;
    logic [DATA_W-1:0] alu_result;
    logic              alu_zero;
    logic              branch_cond;
    ex_mem_t           ex_mem_d;
    ex_mem_t           ex_mem_q;

    assign op_b = bus.ID_EX_ALUSrc ? bus.ID_EX_SignExtImm : bus.ID_EX_ReadData2;

    alu32 u_alu (
        .a      (bus.ID_EX_ReadData1),
        .b      (op_b),
        .op     (bus.ID_EX_ALUOp),
        .result (alu_result),
        .zero   (alu_zero)
    );

    // BEQ/BNE produce A-B, so a zero result means the operands are equal;
    // any other opcode with Branch set is an unconditional jump.
    always_comb begin
        branch_cond = 1'b1;
        case (bus.ID_EX_ALUOp)
            ALU_BEQ: branch_cond = alu_zero;
            ALU_BNE: branch_cond = !alu_zero;
            default: branch_cond = 1'b1;
        endcase
    end

    always_comb begin
        ex_mem_d               = '0;
        ex_mem_d.alu_result    = alu_result;
        ex_mem_d.write_data    = bus.ID_EX_ReadData2;
        ex_mem_d.write_reg     = bus.ID_EX_RegDst ? bus.ID_EX_Rd : bus.ID_EX_Rb;
        ex_mem_d.mem_write     = bus.ID_EX_MemWrite;
        ex_mem_d.mem_to_reg    = bus.ID_EX_MemtoReg;
        ex_mem_d.reg_write     = bus.ID_EX_RegWrite;
        ex_mem_d.mem_read      = bus.ID_EX_MemRead;
        ex_mem_d.branch_taken  = bus.ID_EX_Branch & branch_cond;
        ex_mem_d.branch_target = bus.ID_EX_PC + bus.ID_EX_SignExtImm[PC_W-1:0];
    end

    // NOTE: non-blocking assignment so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ex_mem_q <= '0;
        end else begin
            ex_mem_q <= ex_mem_d;
        end
    end

    assign bus.EX_MEM_ALUResult    = ex_mem_q.alu_result;
    assign bus.EX_MEM_WriteData    = ex_mem_q.write_data;
    assign bus.EX_MEM_WriteReg     = ex_mem_q.write_reg;
    assign bus.EX_MEM_MemWriteOut  = ex_mem_q.mem_write;
    assign bus.EX_MEM_MemtoRegOut  = ex_mem_q.mem_to_reg;
    assign bus.EX_MEM_RegWrite     = ex_mem_q.reg_write;
    assign bus.EX_MEM_MemReadOut   = ex_mem_q.mem_read;
    assign bus.EX_MEM_Branch       = ex_mem_q.branch_taken;
    assign bus.EX_MEM_BranchTarget = ex_mem_q.branch_target;

endmodule

// File: tb/tb_ex_stage.sv
// Self-checking bench for ex_stage: directed cases plus random vectors compared
// against a behavioural reference of the execute-stage rules.
module tb_ex_stage;
    import proc_pkg::*;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    ex_stage_if bus ();

    ex_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] imm;
        logic [4:0]  rb;
        logic [4:0]  rd;
        logic [7:0]  pc;
        logic        regdst;
        logic        alusrc;
        logic        memtoreg;
        logic        regwrite;
        logic        memread;
        logic        memwrite;
        logic        branch;
        logic [4:0]  op;
    } stim_t;

    int n_pass  = 0;
    int n_total = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    function automatic stim_t zero_stim();
        stim_t s;
        s = '{rd1: 32'd0, rd2: 32'd0, imm: 32'd0, rb: 5'd0, rd: 5'd0, pc: 8'd0,
              regdst: 1'b0, alusrc: 1'b0, memtoreg: 1'b0, regwrite: 1'b0,
              memread: 1'b0, memwrite: 1'b0, branch: 1'b0, op: 5'd0};
        return s;
    endfunction

    task automatic drive(input stim_t s);
        bus.ID_EX_ReadData1  = s.rd1;
        bus.ID_EX_ReadData2  = s.rd2;
        bus.ID_EX_SignExtImm = s.imm;
        bus.ID_EX_Rb         = s.rb;
        bus.ID_EX_Rd         = s.rd;
        bus.ID_EX_PC         = s.pc;
        bus.ID_EX_RegDst     = s.regdst;
        bus.ID_EX_ALUSrc     = s.alusrc;
        bus.ID_EX_MemtoReg   = s.memtoreg;
        bus.ID_EX_RegWrite   = s.regwrite;
        bus.ID_EX_MemRead    = s.memread;
        bus.ID_EX_MemWrite   = s.memwrite;
        bus.ID_EX_Branch     = s.branch;
        bus.ID_EX_ALUOp      = s.op;
    endtask

    // Reference ALU written from the opcode table with plain arithmetic.
    function automatic logic [31:0] ref_alu(input stim_t s);
        logic [31:0] a, b, r;
        int unsigned sh;
        a  = s.rd1;
        b  = s.alusrc ? s.imm : s.rd2;
        sh = b % 32;
        case (int'(s.op))
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = ~(a | b);
            6:  r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            7:  r = (a < b) ? 32'd1 : 32'd0;
            8:  r = a << sh;
            9:  r = a >> sh;
            10: begin
                r = a >> sh;
                if (a[31] && sh != 0) r = r | ~(32'hFFFF_FFFF >> sh);
            end
            11: r = b * 32'd65536;
            12: r = b;
            13, 14: r = a - b;
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    function automatic logic ref_taken(input stim_t s);
        logic [31:0] b;
        b = s.alusrc ? s.imm : s.rd2;
        if (!s.branch) return 1'b0;
        if (s.op == 5'd13) return s.rd1 == b;
        if (s.op == 5'd14) return s.rd1 != b;
        return 1'b1;
    endfunction

    task automatic check_outputs(input string tag, input stim_t s);
        int tgt;
        logic [7:0] imm_lo;
        imm_lo = s.imm[7:0];
        tgt    = (int'(s.pc) + int'(imm_lo)) % 256;
        check({tag, ".alu"},    bus.EX_MEM_ALUResult, ref_alu(s));
        check({tag, ".wdata"},  bus.EX_MEM_WriteData, s.rd2);
        check({tag, ".wreg"},   32'(bus.EX_MEM_WriteReg), 32'(s.regdst ? s.rd : s.rb));
        check({tag, ".memwr"},  32'(bus.EX_MEM_MemWriteOut), 32'(s.memwrite));
        check({tag, ".m2r"},    32'(bus.EX_MEM_MemtoRegOut), 32'(s.memtoreg));
        check({tag, ".regwr"},  32'(bus.EX_MEM_RegWrite), 32'(s.regwrite));
        check({tag, ".memrd"},  32'(bus.EX_MEM_MemReadOut), 32'(s.memread));
        check({tag, ".taken"},  32'(bus.EX_MEM_Branch), 32'(ref_taken(s)));
        check({tag, ".target"}, 32'(bus.EX_MEM_BranchTarget), tgt[31:0]);
    endtask

    task automatic check_zero(input string tag);
        logic [31:0] all_or;
        all_or = bus.EX_MEM_ALUResult | bus.EX_MEM_WriteData | 32'(bus.EX_MEM_WriteReg)
               | 32'(bus.EX_MEM_BranchTarget)
               | 32'({bus.EX_MEM_MemWriteOut, bus.EX_MEM_MemtoRegOut, bus.EX_MEM_RegWrite,
                      bus.EX_MEM_MemReadOut, bus.EX_MEM_Branch});
        check({tag, ".all_zero"}, all_or, 32'd0);
    endtask

    // Apply one vector, take one edge, sample 1ns later.
    task automatic run(input string tag, input stim_t s);
        drive(s);
        @(posedge clk);
        #1;
        check_outputs(tag, s);
    endtask

    initial begin
        stim_t s;

        rst = 1'b1;
        drive(zero_stim());
        #22;
        check_zero("reset");
        @(negedge clk);
        rst = 1'b0;

        // LW address
        s = zero_stim();
        s.rd1 = 32'h10; s.imm = 32'd4; s.alusrc = 1'b1; s.op = ALU_ADD;
        s.regdst = 1'b1; s.rd = 5'd3; s.memread = 1'b1; s.memtoreg = 1'b1; s.regwrite = 1'b1;
        run("lw", s);
        check("lw.alu_const", bus.EX_MEM_ALUResult, 32'h14);
        check("lw.wreg_const", 32'(bus.EX_MEM_WriteReg), 32'd3);

        // SW address and store data
        s = zero_stim();
        s.rd1 = 32'h20; s.imm = 32'hFFFF_FFFC; s.rd2 = 32'hDEAD_BEEF; s.alusrc = 1'b1;
        s.memwrite = 1'b1; s.op = ALU_ADD;
        run("sw", s);
        check("sw.alu_const", bus.EX_MEM_ALUResult, 32'h1C);
        check("sw.wdata_const", bus.EX_MEM_WriteData, 32'hDEAD_BEEF);

        s = zero_stim(); s.rd1 = 32'd0; s.rd2 = 32'd1; s.op = ALU_SUB;
        run("sub", s);
        check("sub.const", bus.EX_MEM_ALUResult, 32'hFFFF_FFFF);

        s = zero_stim(); s.rd1 = 32'hFFFF_FFFF; s.rd2 = 32'd1; s.op = ALU_SLT;
        run("slt", s);
        check("slt.const", bus.EX_MEM_ALUResult, 32'd1);
        s.op = ALU_SLTU;
        run("sltu", s);
        check("sltu.const", bus.EX_MEM_ALUResult, 32'd0);

        s = zero_stim(); s.rd1 = 32'h8000_0000; s.imm = 32'd4; s.alusrc = 1'b1; s.op = ALU_SRA;
        run("sra", s);
        check("sra.const", bus.EX_MEM_ALUResult, 32'hF800_0000);

        // Branches
        s = zero_stim(); s.rd1 = 32'd5; s.rd2 = 32'd5; s.branch = 1'b1; s.pc = 8'h10;
        s.imm = 32'hFFFF_FFF8; s.op = ALU_BEQ;
        run("beq_t", s);
        check("beq_t.taken_const", 32'(bus.EX_MEM_Branch), 32'd1);
        check("beq_t.target_const", 32'(bus.EX_MEM_BranchTarget), 32'h08);
        s.rd1 = 32'd6;
        run("beq_nt", s);
        check("beq_nt.taken_const", 32'(bus.EX_MEM_Branch), 32'd0);
        check("beq_nt.target_const", 32'(bus.EX_MEM_BranchTarget), 32'h08);
        s.op = ALU_BNE;
        run("bne_t", s);
        check("bne_t.taken_const", 32'(bus.EX_MEM_Branch), 32'd1);

        s = zero_stim(); s.pc = 8'hFE; s.imm = 32'd4; s.branch = 1'b1; s.op = ALU_ADD;
        run("wrap", s);
        check("wrap.target_const", 32'(bus.EX_MEM_BranchTarget), 32'h02);

        s = zero_stim(); s.rb = 5'd7; s.rd = 5'd9; s.regdst = 1'b0; s.rd1 = 32'h1234;
        s.rd2 = 32'h5678; s.op = 5'd20;
        run("rb_sel", s);
        check("rb_sel.wreg_const", 32'(bus.EX_MEM_WriteReg), 32'd7);
        check("op20.alu_const", bus.EX_MEM_ALUResult, 32'd0);

        // Asynchronous reset between edges
        s = zero_stim();
        s.rd1 = 32'hA5A5_0001; s.rd2 = 32'h0F0F_0F0F; s.imm = 32'h33; s.pc = 8'h40;
        s.regdst = 1'b1; s.rd = 5'd12; s.memread = 1'b1; s.memwrite = 1'b1;
        s.memtoreg = 1'b1; s.regwrite = 1'b1; s.branch = 1'b1; s.op = ALU_OR;
        run("preload", s);
        #2;
        rst = 1'b1;
        #1;
        check_zero("async_rst");
        @(posedge clk);
        #1;
        check_zero("held_rst");
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_outputs("post_rst", s);

        // Random vectors; a quarter are BEQ/BNE with equal operands to hit the taken/not-taken split.
        for (int i = 0; i < 300; i++) begin
            s.rd1      = $urandom();
            s.rd2      = $urandom();
            s.imm      = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom();
            s.rb       = 5'($urandom_range(0, 31));
            s.rd       = 5'($urandom_range(0, 31));
            s.pc       = 8'($urandom_range(0, 255));
            s.regdst   = 1'($urandom_range(0, 1));
            s.alusrc   = 1'($urandom_range(0, 1));
            s.memtoreg = 1'($urandom_range(0, 1));
            s.regwrite = 1'($urandom_range(0, 1));
            s.memread  = 1'($urandom_range(0, 1));
            s.memwrite = 1'($urandom_range(0, 1));
            s.branch   = 1'($urandom_range(0, 1));
            s.op       = 5'($urandom_range(0, 31));
            if ($urandom_range(0, 3) == 0) begin
                s.op = ($urandom_range(0, 1) == 1) ? ALU_BEQ : ALU_BNE;
                if (s.alusrc) s.rd1 = s.imm;
                else s.rd1 = s.rd2;
            end
            run("rand", s);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
